// File: rtl/node_mac_pipe.sv
// node_mac_pipe: pipelined neuron node.
// Streams LANES-wide weight/input beats, multiplies lane-wise, reduces each beat,
// accumulates BEATS beats per node, adds bias, requantises, saturates, optional ReLU.
// valid/ready flow control on both sides; clr flushes any partial node.
module node_mac_pipe #(
  parameter int LANES     = 16,
  parameter int DW        = 8,
  parameter int BEATS     = 4,
  parameter int OUT_SHIFT = 6,
  parameter int RELU      = 1,
  localparam int ACC_W    = 2*DW + 2 + $clog2(LANES*BEATS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] a,
  input  logic [LANES*DW-1:0] b,
  input  logic [DW-1:0]       bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       p
);

  localparam int PW    = 2*DW + 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Flow control: the whole pipeline advances together unless a result is stuck at the output.
  logic en;
  logic accept;
  logic first;
  logic last;

  logic [CNT_W-1:0] cnt_reg;
  logic [DW-1:0]    bias_hold_reg;
  logic [DW-1:0]    bias_tag;

  // S1 state
  logic signed [PW-1:0] prod_next [LANES];
  logic signed [PW-1:0] prod_reg  [LANES];
  logic                 v1_reg, f1_reg, l1_reg;
  logic [DW-1:0]        b1_reg;

  // S2 state
  logic signed [ACC_W-1:0] sum_next;
  logic signed [ACC_W-1:0] sum_reg;
  logic                    v2_reg, f2_reg, l2_reg;
  logic [DW-1:0]           b2_reg;

  // S3 state
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] r_next;
  logic signed [ACC_W-1:0] r_reg;
  logic                    v3_reg;

  // Output state
  logic [DW-1:0] p_next;
  logic [DW-1:0] p_reg;
  logic          out_valid_reg;

  assign en        = !(out_valid_reg && !out_ready);
  assign in_ready  = en;
  assign accept    = in_valid && en && !clr;
  assign first     = (cnt_reg == '0);
  assign last      = (cnt_reg == CNT_W'(BEATS-1));
  // Later beats of a node reuse the bias captured on its first beat.
  assign bias_tag  = first ? bias : bias_hold_reg;
  assign out_valid = out_valid_reg;
  assign p         = p_reg;

  // Beat counter and bias capture on the first beat of each node.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      bias_hold_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= last ? '0 : cnt_reg + CNT_W'(1);
      if (first) bias_hold_reg <= bias;
    end
  end

  // Per-lane signed(a) x unsigned(b) product, registered on accept.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0] a_lane;
    logic [DW-1:0] b_lane;
    assign a_lane = a[(LANES-1-gi)*DW +: DW];
    assign b_lane = b[(LANES-1-gi)*DW +: DW];
    assign prod_next[gi] = $signed({{(DW+1){a_lane[DW-1]}}, a_lane}) *
                           $signed({{(DW+1){1'b0}}, b_lane});

    // Lane product register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        prod_reg[gi] <= '0;
      else if (accept) prod_reg[gi] <= prod_next[gi];
    end
  end

  // S1 valid and node tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg <= 1'b0;
      f1_reg <= 1'b0;
      l1_reg <= 1'b0;
      b1_reg <= '0;
    end else if (clr) begin
      v1_reg <= 1'b0;
    end else if (en) begin
      v1_reg <= accept;
      if (accept) begin
        f1_reg <= first;
        l1_reg <= last;
        b1_reg <= bias_tag;
      end
    end
  end

  // Reduce the S1 lane products into one sign-extended beat sum.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_next = sum_next + {{(ACC_W-PW){prod_reg[i][PW-1]}}, prod_reg[i]};
    end
  end

  // S2 beat sum and tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_reg  <= 1'b0;
      f2_reg  <= 1'b0;
      l2_reg  <= 1'b0;
      b2_reg  <= '0;
      sum_reg <= '0;
    end else if (clr) begin
      v2_reg <= 1'b0;
    end else if (en) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sum_reg <= sum_next;
        f2_reg  <= f1_reg;
        l2_reg  <= l1_reg;
        b2_reg  <= b1_reg;
      end
    end
  end

  // Accumulate the beat; on the last beat fold in the scaled bias and requantise.
  always_comb begin
    base     = f2_reg ? '0 : acc_reg;
    acc_sum  = base + sum_reg;
    bias_ext = {{(ACC_W-DW){b2_reg[DW-1]}}, b2_reg};
    biased   = acc_sum + (bias_ext <<< OUT_SHIFT);
    r_next   = biased >>> OUT_SHIFT;
  end

  // S3 accumulator and requantised node result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
      r_reg   <= '0;
      v3_reg  <= 1'b0;
    end else if (clr) begin
      acc_reg <= '0;
      v3_reg  <= 1'b0;
    end else if (en) begin
      v3_reg <= v2_reg && l2_reg;
      if (v2_reg) begin
        if (l2_reg) begin
          r_reg   <= r_next;
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_sum;
        end
      end
    end
  end

  // Saturate to DW bits, then optionally clamp negatives to zero.
  always_comb begin
    if (r_reg > SAT_MAX)      p_next = {1'b0, {(DW-1){1'b1}}};
    else if (r_reg < SAT_MIN) p_next = {1'b1, {(DW-1){1'b0}}};
    else                      p_next = r_reg[DW-1:0];
    if ((RELU != 0) && p_next[DW-1]) p_next = '0;
  end

  // Output register: p only moves when a new result loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      p_reg         <= '0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
    end else if (en) begin
      out_valid_reg <= v3_reg;
      if (v3_reg) p_reg <= p_next;
    end
  end

endmodule

// File: tb/tb_node_mac_pipe.sv
// Self-checking bench for node_mac_pipe: directed and randomised nodes,
// backpressure, reset/flush mid-node, and a narrow single-beat configuration.
module tb_node_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clr, in_valid, out_ready;
  logic [127:0] a, b;
  logic [7:0]   bias;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [7:0]   p0, p1;

  logic         clr2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0]  a2, b2;
  logic [7:0]   bias2, p2;

  node_mac_pipe dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .bias(bias), .out_valid(out_valid0), .out_ready(out_ready), .p(p0)
  );

  node_mac_pipe #(.RELU(0)) dut_norelu (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .bias(bias), .out_valid(out_valid1), .out_ready(out_ready), .p(p1)
  );

  node_mac_pipe #(.LANES(4), .BEATS(1), .OUT_SHIFT(0)) dut_small (
    .clk(clk), .rst(rst), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .bias(bias2), .out_valid(out_valid2), .out_ready(out_ready2), .p(p2)
  );

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;

  logic [7:0]   obs0[$], obs1[$], obs2[$], exp0[$], exp1[$], exp2[$];
  logic [127:0] nav[4], nbv[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  // Reference: plain integer dot product, bias scaled, floor shift, clamp, ReLU.
  function automatic logic [7:0] model(input logic [127:0] av[4], input logic [127:0] bv[4],
                                       input logic [7:0] nb, input int lanes, input int beats,
                                       input int shift, input int relu);
    longint s;
    logic [7:0] ea, eb;
    s = 0;
    for (int k = 0; k < beats; k++) begin
      for (int i = 0; i < lanes; i++) begin
        ea = av[k][(lanes-1-i)*8 +: 8];
        eb = bv[k][(lanes-1-i)*8 +: 8];
        s += longint'($signed(ea)) * longint'({24'd0, eb});
      end
    end
    s += longint'($signed(nb)) * (longint'(1) << shift);
    s = s >>> shift;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (relu != 0 && s < 0) s = 0;
    return s[7:0];
  endfunction

  // Output monitors: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst && !clr && out_valid0 && out_ready) obs0.push_back(p0);
    if (rst && !clr && out_valid1 && out_ready) obs1.push_back(p1);
    if (rst && !clr2 && out_valid2 && out_ready2) obs2.push_back(p2);
  end

  task automatic send_beat(input logic [127:0] av, input logic [127:0] bv, input logic [7:0] nb);
    bit took;
    a = av; b = bv; bias = nb; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      took = in_ready0 && !clr;
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      if (took) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("beat_accept_timeout", 32'(took), 32'd1);
    in_valid = 1'b0;
  endtask

  // Later beats carry junk bias: only the first beat's bias may count.
  task automatic send_node(input logic [127:0] av[4], input logic [127:0] bv[4], input logic [7:0] nb);
    for (int k = 0; k < 4; k++) send_beat(av[k], bv[k], (k == 0) ? nb : 8'($urandom));
    exp0.push_back(model(av, bv, nb, 16, 4, 6, 1));
    exp1.push_back(model(av, bv, nb, 16, 4, 6, 0));
  endtask

  task automatic fill(input logic [7:0] ea, input logic [7:0] eb);
    for (int k = 0; k < 4; k++) begin
      nav[k] = {16{ea}};
      nbv[k] = {16{eb}};
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare_queues(input string tag);
    check($sformatf("%s_count_relu", tag), obs0.size(), exp0.size());
    check($sformatf("%s_count_norelu", tag), obs1.size(), exp1.size());
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++)
      check($sformatf("%s_p_relu[%0d]", tag, i), obs0[i], exp0[i]);
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++)
      check($sformatf("%s_p_norelu[%0d]", tag, i), obs1[i], exp1[i]);
    obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
  endtask

  initial begin
    int lat;
    logic [127:0] av2[4], bv2[4];

    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bias = '0;
    clr2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; bias2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_p", 32'(p0), 32'd0);
    check("rst_p_small", 32'(p2), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;

    // Unit node and output latency
    fill(8'h01, 8'h01);
    send_node(nav, nbv, 8'h00);
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1;
      if (out_valid0) begin
        lat = t;
        break;
      end
    end
    check("latency", lat, 3);
    drain();
    compare_queues("unit");

    // Bias, including negative bias with and without ReLU
    send_node(nav, nbv, 8'h02);
    send_node(nav, nbv, 8'hFE);
    drain();
    compare_queues("bias");

    // Saturation at both ends
    fill(8'h7F, 8'hFF);
    send_node(nav, nbv, 8'h00);
    fill(8'h80, 8'hFF);
    send_node(nav, nbv, 8'h00);
    drain();
    compare_queues("sat");

    // Backpressure: two nodes back-to-back while downstream is stalled
    out_ready = 1'b0;
    fill(8'h01, 8'h01);
    send_node(nav, nbv, 8'h00);
    fork
      send_node(nav, nbv, 8'h02);
      begin
        repeat (8) @(posedge clk);
        #1;
        check("bp_out_valid", 32'(out_valid0), 32'd1);
        check("bp_in_ready", 32'(in_ready0), 32'd0);
        check("bp_p_held", 32'(p0), 32'h01);
        repeat (3) @(posedge clk);
        #1;
        check("bp_p_still_held", 32'(p0), 32'h01);
        check("bp_nothing_out", obs0.size(), 0);
        out_ready = 1'b1;
      end
    join
    drain();
    compare_queues("bp");

    // Reset in the middle of a node
    send_beat(nav[0], nbv[0], 8'h00);
    send_beat(nav[1], nbv[1], 8'h00);
    rst = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid0), 32'd0);
    check("midrst_p", 32'(p0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_node(nav, nbv, 8'h00);
    drain();
    compare_queues("midrst");

    // Flush in the middle of a node; the beat presented with clr is dropped
    send_beat(nav[0], nbv[0], 8'h00);
    send_beat(nav[1], nbv[1], 8'h00);
    a = nav[2]; b = nbv[2]; bias = 8'h00; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", 32'(out_valid0), 32'd0);
    check("clr_p_unchanged", 32'(p0), 32'h01);
    send_node(nav, nbv, 8'h02);
    drain();
    compare_queues("clr");

    // Random nodes with random downstream readiness
    rand_rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) begin
        nav[k] = {$urandom, $urandom, $urandom, $urandom};
        nbv[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      send_node(nav, nbv, 8'($urandom));
    end
    drain();
    compare_queues("rand");

    // Narrow configuration: one result per beat
    for (int n = 0; n < 8; n++) begin
      if (n < 4) begin
        a2 = 32'h03030303; b2 = 32'h02020202; bias2 = 8'h01;
      end else begin
        a2 = $urandom; b2 = $urandom; bias2 = 8'($urandom);
      end
      for (int k = 0; k < 4; k++) begin
        av2[k] = '0;
        bv2[k] = '0;
      end
      av2[0] = {96'd0, a2};
      bv2[0] = {96'd0, b2};
      exp2.push_back(model(av2, bv2, bias2, 4, 1, 0, 1));
      in_valid2 = 1'b1;
      @(negedge clk);
      check($sformatf("small_in_ready[%0d]", n), 32'(in_ready2), 32'd1);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("small_stream_out_valid", 32'(out_valid2), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("small_count", obs2.size(), exp2.size());
    for (int i = 0; i < obs2.size() && i < exp2.size(); i++)
      check($sformatf("small_p[%0d]", i), obs2[i], exp2[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/node_mac_pipe.md
Name: node_mac_pipe

Overview:
- Parametrised, pipelined neuron node. Streams a node's weight/input vectors in LANES-wide beats and multiplies lane-wise.
- Accumulates BEATS beats, adds a per-node bias, requantises by arithmetic right shift, saturates, and optionally applies ReLU.
- Successor to the fixed 16-byte nodeFunc datapath: adds valid/ready flow control, backpressure, configurable shape and flush.
- Sits between the weight/feature buffers and the layer output collector.

Parameters:
- LANES, 16, multiply lanes per beat
- DW, 8, element width of a, b, bias, p
- BEATS, 4, beats per node (fan-in = LANES*BEATS)
- OUT_SHIFT, 6, right shift applied to the biased accumulator
- RELU, 1, 1 = clamp negative results to 0
- ACC_W, 2*DW+2+$clog2(LANES*BEATS), accumulator width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- clr  in  1  synchronous flush, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- a  in  LANES*DW  weights, signed two's complement per lane, lane 0 in MSBs
- b  in  LANES*DW  inputs, unsigned per lane, lane 0 in MSBs
- bias  in  DW  signed bias, sampled only on a node's first beat
- out_valid  out  1  p valid
- out_ready  in  1  downstream accepts p
- p  out  DW  signed node result

Behaviour:
- Reset (rst=0, async): in_ready=1 once released, out_valid=0, p=0. Beat counter, accumulator, stage valids and tags all cleared. Reset mid-node discards the partial node.
- Beat counter 0..BEATS-1: increments per accepted beat, wraps to 0 after BEATS-1.
  - Count 0 tags the beat `first` and captures bias.
  - Count BEATS-1 tags the beat `last`.
  - BEATS=1: every beat is both first and last.
- Pipeline enable: en = !(out_valid && !out_ready). in_ready = en. All stages hold when en=0.
- S1 (cycle after accept): register LANES products a[i]*b[i] as signed 2*DW+1 bits, plus valid, first, last and bias tags.
- S2: register the adder-tree sum of the S1 products, sign-extended to ACC_W. Tags pass through.
- S3 accumulation:
  - base = first ? 0 : acc.
  - Not last: acc <= base + sum.
  - Last: r = (base + sum + (sext(bias) << OUT_SHIFT)) >>> OUT_SHIFT, then acc <= 0.
- Output stage:
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - If RELU=1, negative results become 0.
  - Load p and set out_valid=1.
- Latency: out_valid rises 3 cycles after the last beat's handshake when unstalled. Throughput is one beat per cycle, so back-to-back nodes are allowed. Tags keep each node's bias with its own beats.
- Output handshake: out_valid && out_ready clears out_valid unless a new result loads in the same cycle. p holds stable while out_valid=1 and out_ready=0.
- Backpressure: while stalled, no beat is accepted and no stage state changes. No data is lost or duplicated.
- clr=1: beat counter, stage valids, acc and out_valid go to 0 next edge. No beat is accepted that cycle (in_ready may read 1, but the beat is dropped). clr has priority over all other updates.
- p does not change except on a result load or reset.

Test Plan:
1. Defaults, a=0x01 all lanes, b=0x01, bias=0x00, 4 beats, out_ready=1 -> 64>>6, p=0x01. out_valid rises exactly 3 cycles after the 4th handshake.
2. Bias: same data, bias=0x02 -> (64+128)>>6, p=0x03. Bias=0xFE with RELU=1 -> p=0x00. Bias=0xFE with RELU=0 -> p=0xFF.
3. Saturation: a=0x7F, b=0xFF, 4 beats -> 2072640>>6=32385, p=0x7F. a=0x80, b=0xFF with RELU=0 -> p=0x80. Same with RELU=1 -> p=0x00.
4. Backpressure: stream nodes A (a=1,b=1,bias=0) and B (bias=0x02) back-to-back with out_ready=0.
   - in_ready drops while out_valid=1 and p=0x01 holds.
   - Raising out_ready yields p=0x01 then p=0x03, in order, none lost.
5. Reset/flush: deassert rst after 2 beats of a node -> outputs 0, no result emitted; the next 4 beats give one correct node. Repeat using clr=1 -> same result.
6. Parameter sweep: LANES=4, BEATS=1, OUT_SHIFT=0, a=0x03, b=0x02, bias=0x01 -> one result per beat, p=0x19 (4*6+1=25).
